// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the synchronous counter family.
package cnt_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int clog2(input longint unsigned v);
        int r;
        longint unsigned x;
        r = 0;
        x = (v > 64'd0) ? v - 64'd1 : 64'd0;
        while (x != 64'd0) begin
            x = x >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// One counter bit: rising-edge T flip-flop with synchronous clear and parallel load.
module tff_cell (
    input  logic clk,
    input  logic clr,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (ld)
            q_d = d;
        else if (t)
            q_d = ~q_q;
    end

    always_ff @(posedge clk) begin
        if (clr)
            q_q <= 1'b0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous up/down modulo counter with load, enable and a cascadable terminal count.
module sync_mod_counter
    import cnt_pkg::*;
#(
    parameter int              WIDTH   = 6,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] tgl;
    logic             at_term;
    logic             wrap_q;
    logic             wrap_d;

    always_comb begin
        next_count = count_q;
        at_term    = 1'b0;
        if (up == CNT_UP) begin
            at_term    = (count_q == MAX_C);
            next_count = at_term ? '0 : count_q + WIDTH'(1);
        end else begin
            at_term    = (count_q == '0);
            next_count = at_term ? MAX_C : count_q - WIDTH'(1);
        end
        // With a full binary modulus MAX_C is all ones and this never saturates.
        sat_val = (load_val > MAX_C) ? MAX_C : load_val;
        tc      = en & at_term;
        wrap_d  = tc & ~load;
        // Only bits that differ from the next value toggle; en gating keeps X on up harmless.
        tgl     = {WIDTH{en}} & (next_count ^ count_q);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk (clk),
            .clr (clr),
            .ld  (load),
            .d   (sat_val[i]),
            .t   (tgl[i]),
            .q   (count_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clr)
            wrap_q <= 1'b0;
        else
            wrap_q <= wrap_d;
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule
